fpu_ret_queue: RTL
==================

Name: fpu_ret_queue

Overview:
- Downstream of the three-lane FPU cluster (lanes u1/u3/u5).
- Captures per-lane completion reports (14-bit ret + ret_en) every cycle and compacts them into an in-order FIFO.
- Drains up to two entries per cycle to the retire/ROB side over a valid/ready handshake.
- Accumulates IEEE exception flags of drained entries into a sticky fflags register.

Parameters:
DEPTH, 8, FIFO entries; power of two, minimum 4.
AW, 3, pointer width = log2(DEPTH).

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
u1_ret  in  14  lane-1 report: [13:5] tag, [4:0] flags {NV,DZ,OF,UF,NX}
u1_ret_en  in  1  lane-1 report valid
u3_ret  in  14  lane-3 report, same format
u3_ret_en  in  1  lane-3 valid
u5_ret  in  14  lane-5 report, same format
u5_ret_en  in  1  lane-5 valid
in_stall  out  1  registered; asserted when free entries < 3
out0_data  out  14  oldest entry
out0_vld  out  1  out0_data valid
out1_data  out  14  second-oldest entry
out1_vld  out  1  out1_data valid; never asserted without out0_vld
out_rdy  in  1  consumer accepts all asserted out*_vld this cycle
fflags  out  5  sticky OR of flags of popped entries
fflags_clr  in  1  clear fflags
ovf  out  1  sticky overflow error

Behaviour:
- Reset: pointers 0, count 0, in_stall=0, out0_vld=out1_vld=0, out*_data=0, fflags=0, ovf=0. Reset mid-operation discards all entries and same-cycle inputs.
- Push:
  - Enabled reports are compacted in fixed order u1, u3, u5 and written at wr_ptr, wr_ptr+1, wr_ptr+2 (mod DEPTH).
  - push_n = popcount(ret_en), 0..3. Pointers wrap modulo DEPTH.
- Pop:
  - pop_n = out_rdy ? (out0_vld + out1_vld) : 0.
  - out0_vld = count>=1; out1_vld = count>=2.
  - out0_data = mem[rd_ptr]; out1_data = mem[rd_ptr+1]. Data is from registered storage, so latency is 1 cycle from push to visibility.
  - Data on an invalid slot is don't-care but must be 0 for the bench (mask with vld).
- Count: count_next = count + push_n - pop_n. Pop uses the pre-push count; a same-cycle push is never popped.
- Space check:
  - Free space for this cycle's push = DEPTH - count + pop_n, so popping frees space in the same cycle.
  - If push_n exceeds free space, accept only the first free-many in lane order, drop the rest, and set ovf (sticky until rst).
- in_stall: registered, = (DEPTH - count_next) < 3. Upstream must not issue while it is set; ovf flags a protocol violation.
- fflags:
  - fflags_next = (fflags_clr ? 0 : fflags) | (popped flags).
  - Popped flags = OR of flags[4:0] of the entries popped this cycle.
  - With simultaneous clr and pop, the popped flags survive.
- Full (count=DEPTH): pushes are dropped unless pops free space. Empty: both vld=0 and out_rdy is ignored.

Optional Feature:
FPRET_BYPASS_EN
- Defined:
  - When count=0, u1/u3/u5 reports are presented combinationally on out0/out1 in compaction order in the same cycle.
  - If out_rdy=1 they retire with zero latency and are not written.
  - Any third report, or any unaccepted reports, are written to the FIFO normally.
  - fflags includes bypassed flags.
- Undefined: no bypass; minimum push-to-out latency is 1 cycle.

Test Plan:
- After rst, all three lanes enabled with tags 1,2,3 and flags 0, out_rdy=0 -> next cycle count=3, out0=tag1, out1=tag2, both vld=1; in_stall=0 (free 5).
- Push 3/cycle for 2 cycles with out_rdy=0 (DEPTH=8) -> count=6, in_stall=1; a further push of 3 -> 2 accepted (u1,u3), u5 dropped, ovf=1, count=8.
- Only u3 and u5 enabled (tags 9, 10) -> stored in order 9 then 10 at consecutive slots; wrap test with wr_ptr=7 places tag10 at slot 0.
- Entries with flags 5'b00001 and 5'b10000 popped together with out_rdy=1 -> fflags=5'b10001; fflags_clr with a same-cycle pop of flags 5'b00100 -> fflags=5'b00100.
- count=8 with out_rdy=1 (pop 2) and push 3 -> accepts 2, drops 1, ovf=1, count stays 8.
- Assert rst with count=5 and a push active -> next cycle count=0, vld=0, fflags=0, ovf=0.

Source files
------------

// File: rtl/fpu_ret_queue_if.sv
// fpu_ret_queue_if: retire-side handshake between fpu_ret_queue and the ROB.
//   out0_data/out0_vld : oldest entry and its valid
//   out1_data/out1_vld : second-oldest entry and its valid (never without out0_vld)
//   out_rdy            : consumer takes every asserted valid this cycle
// modport master = queue side, modport slave = retire/ROB side.
interface fpu_ret_queue_if;
    logic [13:0] out0_data;
    logic        out0_vld;
    logic [13:0] out1_data;
    logic        out1_vld;
    logic        out_rdy;

    modport master (
        output out0_data, out0_vld, out1_data, out1_vld,
        input  out_rdy
    );

    modport slave (
        input  out0_data, out0_vld, out1_data, out1_vld,
        output out_rdy
    );
endinterface

// File: rtl/fpu_ret_queue.sv
// fpu_ret_queue: collects completion reports from FPU lanes u1/u3/u5, compacts
// them in lane order into an in-order FIFO, drains up to two entries per cycle
// to the ROB, and keeps a sticky OR of the exception flags of drained entries.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   uN_ret, uN_ret_en   lane report {tag[8:0], flags[4:0]} and its valid
//   in_stall            registered; fewer than 3 free entries after this cycle
//   rob                 retire handshake (fpu_ret_queue_if.master)
//   fflags, fflags_clr  sticky exception flags and their clear
//   ovf                 sticky: a report was dropped for lack of space
//
// Optional build macro FPRET_BYPASS_EN: when the FIFO is empty, lane reports
// are shown on out0/out1 in the same cycle and skip storage if taken.
module fpu_ret_queue #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [13:0] u1_ret,
    input  logic        u1_ret_en,
    input  logic [13:0] u3_ret,
    input  logic        u3_ret_en,
    input  logic [13:0] u5_ret,
    input  logic        u5_ret_en,
    output logic        in_stall,
    fpu_ret_queue_if.master rob,
    output logic [4:0]  fflags,
    input  logic        fflags_clr,
    output logic        ovf
);

    localparam int EW = AW + 2;
    typedef logic [EW-1:0] ext_t;
    typedef logic [AW:0]   cnt_t;
    localparam ext_t DEPTH_E = ext_t'(DEPTH);

    logic [13:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    cnt_t          count;

    logic [13:0] lane_dat [3];
    logic [2:0]  lane_en;
    logic [13:0] comp [4];
    logic [1:0]  push_n;

    logic        byp_act;
    logic        v0, v1;
    logic [13:0] d0, d1;
    logic [1:0]  pop_n;
    logic [1:0]  skip;
    logic [1:0]  fifo_pop;
    logic [1:0]  avail;
    logic [1:0]  wr_n;
    logic        drop;
    ext_t        free_e;
    cnt_t        count_next;
    logic        stall_next;
    logic [4:0]  pop_flags;

    assign lane_dat[0] = u1_ret;
    assign lane_dat[1] = u3_ret;
    assign lane_dat[2] = u5_ret;
    assign lane_en     = {u5_ret_en, u3_ret_en, u1_ret_en};

    // Compaction: enabled reports packed to the front in u1, u3, u5 order.
    always_comb begin
        for (int i = 0; i < 4; i++) comp[i] = '0;
        push_n = '0;
        for (int i = 0; i < 3; i++) begin
            if (lane_en[i]) begin
                comp[push_n] = lane_dat[i];
                push_n       = push_n + 2'd1;
            end
        end
    end

`ifdef FPRET_BYPASS_EN
    assign byp_act = (count == '0);
`else
    assign byp_act = 1'b0;
`endif

    // Output view: stored head entries, or live lane reports while bypassing.
    always_comb begin
        v0 = 1'b0;
        v1 = 1'b0;
        d0 = '0;
        d1 = '0;
        if (byp_act) begin
            v0 = (push_n != 2'd0);
            v1 = (push_n >= 2'd2);
            d0 = comp[0];
            d1 = comp[1];
        end else begin
            v0 = (count != '0);
            v1 = (count >= cnt_t'(2));
            d0 = mem[rd_ptr];
            d1 = mem[rd_ptr + AW'(1)];
        end
        if (!v0) d0 = '0;
        if (!v1) d1 = '0;
    end

    assign rob.out0_vld  = v0;
    assign rob.out1_vld  = v1;
    assign rob.out0_data = d0;
    assign rob.out1_data = d1;

    // Bypassed reports are consumed before storage; stored pops free space
    // for this cycle's pushes.
    always_comb begin
        pop_n      = rob.out_rdy ? ({1'b0, v0} + {1'b0, v1}) : 2'd0;
        skip       = byp_act ? pop_n : 2'd0;
        fifo_pop   = byp_act ? 2'd0 : pop_n;
        avail      = push_n - skip;
        free_e     = DEPTH_E - ext_t'(count) + ext_t'(fifo_pop);
        wr_n       = avail;
        drop       = 1'b0;
        if (ext_t'(avail) > free_e) begin
            // free_e < 3 here, so it fits the 2-bit write count
            wr_n = free_e[1:0];
            drop = 1'b1;
        end
        count_next = count + cnt_t'(wr_n) - cnt_t'(fifo_pop);
        stall_next = (DEPTH_E - ext_t'(count_next)) < ext_t'(3);
        pop_flags  = rob.out_rdy ? (d0[4:0] | d1[4:0]) : 5'd0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int j = 0; j < 3; j++) begin
                if (2'(j) < wr_n) mem[wr_ptr + AW'(j)] <= comp[skip + 2'(j)];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            in_stall <= 1'b0;
            fflags   <= '0;
            ovf      <= 1'b0;
        end else begin
            wr_ptr   <= wr_ptr + AW'(wr_n);
            rd_ptr   <= rd_ptr + AW'(fifo_pop);
            count    <= count_next;
            in_stall <= stall_next;
            fflags   <= (fflags_clr ? 5'd0 : fflags) | pop_flags;
            if (drop) ovf <= 1'b1;
        end
    end

endmodule
